sonar_driver: RTL and testbench
===============================

Name: sonar_driver

Overview:
Responder side of the sonar measure handshake that the command/control FSM initiates.
- On a one-cycle `measure` request, drives the ultrasonic ranger trigger pulse, times the returned echo pulse, converts its width to an 8-bit distance, and returns a one-cycle `ready` strobe with `distance` valid.
- Sits between the control FSM and the sensor pins. Enforces sensor holdoff between shots and never drops a request.

Parameters:
- TRIG_CYCLES, 500: trigger high width in clk cycles (10 us at 50 MHz).
- CYCLES_PER_UNIT, 2900: echo-high clk cycles per distance unit (58 us/cm at 50 MHz).
- TIMEOUT_CYCLES, 1500000: max cycles from entering WAIT_RISE until echo fall (30 ms).
- HOLDOFF_CYCLES, 3000000: idle gap after each result before the next trigger (60 ms).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- measure  in  1  request; one-cycle pulse from the control FSM.
- echo  in  1  sensor echo; asynchronous to clk.
- trig  out  1  sensor trigger.
- ready  out  1  one-cycle strobe: distance/timed_out updated this cycle.
- distance  out  8  last result in units; 255 = saturated or timeout.
- busy  out  1  high in any state other than IDLE.
- timed_out  out  1  last result was a timeout; valid with ready, held until the next result.

Behaviour:
- Clock/reset: single clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, trig=0, ready=0, distance=0, busy=0, timed_out=0, pending=0. All counters 0, sync flops 0.
- Reset mid-operation: outputs take reset values on the first edge with rst=1, regardless of state. Any in-flight measurement is discarded with no ready pulse.
- Echo input: 2-flop synchronizer followed by an edge-detect register. Rise/fall are detected from the synchronized signal, so pulse width is preserved. Latency is 2 cycles.
- IDLE:
  - On measure=1 or pending=1: go to TRIG, set trig=1, clear pending, clear all counters.
  - trig rises on the edge after measure is sampled.
- TRIG: trig stays high for exactly TRIG_CYCLES cycles. It then drops, and the state goes to WAIT_RISE with the timeout counter cleared.
- WAIT_RISE:
  - The timeout counter increments every cycle.
  - A rising edge of synchronized echo moves to ECHO. An echo already high on entry is not a rise.
  - When the counter reaches TIMEOUT_CYCLES: go to DONE with the result set to 255 and timed_out=1.
- ECHO:
  - The timeout counter keeps running.
  - A prescaler counts 0..CYCLES_PER_UNIT-1. Each wrap increments the unit counter, which saturates at 255 (no wrap-around).
  - A falling edge goes to DONE with result = unit counter and timed_out=0. This gives floor(high_cycles/CYCLES_PER_UNIT), capped at 255.
  - On timeout: result 255, timed_out=1.
  - Fall and timeout in the same cycle: the fall wins.
- DONE (one cycle): distance and timed_out are registered, ready=1 for exactly this cycle, then go to HOLDOFF.
- HOLDOFF:
  - Counts HOLDOFF_CYCLES, then goes to IDLE.
  - measure=1 here sets pending, and the trigger starts on the cycle IDLE is re-entered. Requests are never lost.
- measure in TRIG, WAIT_RISE, ECHO or DONE is ignored; the requester does not issue one while awaiting ready.
- Outputs:
  - distance holds its value between results.
  - trig never exceeds TRIG_CYCLES per request.
  - busy is registered; it rises with trig and falls on entry to IDLE.
- Counter widths: each counter is sized by $clog2 of its parameter+1. Units are 8 bits.

Test Plan (sim params TRIG_CYCLES=5, CYCLES_PER_UNIT=10, TIMEOUT_CYCLES=4000, HOLDOFF_CYCLES=50):
- Single measure pulse at cycle N -> trig=1 on cycles N+1..N+5 only, busy=1 from N+1. No second trig without a new request.
- Echo rise 20 cycles after trig falls, high for 237 cycles -> distance=23, timed_out=0, ready high exactly one cycle about 3 cycles after the echo fall, busy low 50 cycles later.
- Echo high 3000 cycles -> distance=255 (saturated), timed_out=0. A following 95-cycle echo -> distance=9.
- Echo never rises -> ready pulse 4000 cycles after WAIT_RISE entry, distance=255, timed_out=1. Echo held high from before trig -> same timeout result.
- Measure during HOLDOFF cycle 10 -> trig rises on the cycle after HOLDOFF ends. Measure pulses during ECHO -> ignored, only one result produced.
- rst=1 for 1 cycle mid-ECHO -> next cycle trig=0, busy=0, distance=0, no ready. A new measure then completes normally (echo 50 cycles -> distance=5).

Source files
------------

// File: rtl/sonar_driver.sv
// Ultrasonic ranger responder: issues the trigger pulse, times the echo,
// converts the echo width to distance units, and enforces holdoff between shots.
module sonar_driver #(
  parameter int unsigned TRIG_CYCLES     = 500,
  parameter int unsigned CYCLES_PER_UNIT = 2900,
  parameter int unsigned TIMEOUT_CYCLES  = 1500000,
  parameter int unsigned HOLDOFF_CYCLES  = 3000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       measure,
  input  logic       echo,
  output logic       trig,
  output logic       ready,
  output logic [7:0] distance,
  output logic       busy,
  output logic       timed_out
);

  localparam int TW = $clog2(TRIG_CYCLES + 1);
  localparam int PW = $clog2(CYCLES_PER_UNIT + 1);
  localparam int OW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

  localparam logic [TW-1:0] TRIG_LAST  = TW'(TRIG_CYCLES - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CYCLES_PER_UNIT - 1);
  localparam logic [OW-1:0] TO_LAST    = OW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLDOFF_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, ECHO, DONE, HOLDOFF} state_t;

  state_t        state_q;
  logic          s1_q, s2_q, prev_q;
  logic          trig_q, ready_q, busy_q, timed_out_q, pending_q;
  logic [7:0]    distance_q;
  logic [TW-1:0] trig_cnt_q;
  logic [PW-1:0] presc_q;
  logic [OW-1:0] to_cnt_q;
  logic [HW-1:0] hold_cnt_q;
  logic [7:0]    units_q, units_d;
  logic          rise, fall, wrap, timeout_hit;

  assign rise        = s2_q & ~prev_q;
  assign fall        = ~s2_q & prev_q;
  assign wrap        = (presc_q == PRESC_LAST);
  assign timeout_hit = (to_cnt_q == TO_LAST);

  // Units including this cycle's wrap, so a fall reports floor(high/CPU).
  always_comb begin
    units_d = units_q;
    if (wrap && units_q != 8'hFF) units_d = units_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      prev_q      <= 1'b0;
      trig_q      <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      timed_out_q <= 1'b0;
      pending_q   <= 1'b0;
      distance_q  <= 8'd0;
      trig_cnt_q  <= '0;
      presc_q     <= '0;
      to_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      units_q     <= 8'd0;
    end else begin
      s1_q    <= echo;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      ready_q <= 1'b0;
      case (state_q)
        IDLE: if (measure || pending_q) begin
          state_q    <= TRIG;
          trig_q     <= 1'b1;
          busy_q     <= 1'b1;
          pending_q  <= 1'b0;
          trig_cnt_q <= '0;
          presc_q    <= '0;
          to_cnt_q   <= '0;
          hold_cnt_q <= '0;
          units_q    <= 8'd0;
        end
        TRIG: begin
          if (trig_cnt_q == TRIG_LAST) begin
            trig_q   <= 1'b0;
            state_q  <= WAIT_RISE;
            to_cnt_q <= '0;
          end else begin
            trig_cnt_q <= trig_cnt_q + 1'b1;
          end
        end
        WAIT_RISE: begin
          to_cnt_q <= to_cnt_q + 1'b1;
          if (rise) begin
            state_q <= ECHO;
            presc_q <= '0;
            units_q <= 8'd0;
          end else if (timeout_hit) begin
            state_q     <= DONE;
            distance_q  <= 8'hFF;
            timed_out_q <= 1'b1;
            ready_q     <= 1'b1;
          end
        end
        ECHO: begin
          to_cnt_q <= to_cnt_q + 1'b1;
          presc_q  <= wrap ? '0 : presc_q + 1'b1;
          units_q  <= units_d;
          // A fall coinciding with the timeout still reports the measured width.
          if (fall) begin
            state_q     <= DONE;
            distance_q  <= units_d;
            timed_out_q <= 1'b0;
            ready_q     <= 1'b1;
          end else if (timeout_hit) begin
            state_q     <= DONE;
            distance_q  <= 8'hFF;
            timed_out_q <= 1'b1;
            ready_q     <= 1'b1;
          end
        end
        DONE: begin
          state_q    <= HOLDOFF;
          hold_cnt_q <= '0;
        end
        HOLDOFF: begin
          if (measure) pending_q <= 1'b1;
          if (hold_cnt_q == HOLD_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign trig      = trig_q;
  assign ready     = ready_q;
  assign distance  = distance_q;
  assign busy      = busy_q;
  assign timed_out = timed_out_q;

endmodule

// File: tb/tb_sonar_driver.sv
// Randomized bench for sonar_driver; expected distances come from the
// floor(width/CPU) capped-at-255 rule applied to the echo widths it drives.
module tb_sonar_driver;
  localparam int TRIG = 5, CPU = 10, TO = 4000, HOLD = 50;

  logic       clk = 1'b0;
  logic       rst, measure, echo;
  logic       trig, ready, busy, timed_out;
  logic [7:0] distance;
  int checks = 0, errors = 0;
  int trig_rises = 0, ready_cnt = 0;
  logic prev_trig = 1'b0;

  always #5 clk = ~clk;

  sonar_driver #(.TRIG_CYCLES(TRIG), .CYCLES_PER_UNIT(CPU),
                 .TIMEOUT_CYCLES(TO), .HOLDOFF_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .measure(measure), .echo(echo), .trig(trig),
    .ready(ready), .distance(distance), .busy(busy), .timed_out(timed_out));

  // Event counters sampled mid-cycle, away from both edges.
  always begin
    @(posedge clk); #2;
    if (trig && !prev_trig) trig_rises++;
    if (ready) ready_cnt++;
    prev_trig = trig;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_dist(input int h);
    return (h / CPU > 255) ? 255 : h / CPU;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(input int budget, output int lat, output bit seen);
    lat = 0; seen = 0;
    while (!seen && lat < budget) begin
      tick(); lat++;
      if (ready) seen = 1;
    end
  endtask

  // Called with trig just observed high; h==0 means no echo is driven.
  task automatic finish_shot(input string tag, input int d, input int h);
    int lat; bit seen;
    lat = 0;
    while (trig && lat < 20) begin tick(); lat++; end
    chk({tag, ".trig_width"}, lat, TRIG);
    if (h > 0) begin
      tick(d); echo = 1'b1; tick(h); echo = 1'b0;
      wait_ready(20, lat, seen);
      chk({tag, ".ready_seen"}, seen, 1);
      chk({tag, ".ready_lat_ok"}, (lat >= 2 && lat <= 4), 1);
      chk({tag, ".distance"}, distance, exp_dist(h));
      chk({tag, ".timed_out"}, timed_out, 0);
    end else begin
      wait_ready(TO + 20, lat, seen);
      chk({tag, ".ready_seen"}, seen, 1);
      chk({tag, ".timeout_lat_ok"}, (lat >= TO - 1 && lat <= TO + 1), 1);
      chk({tag, ".distance"}, distance, 255);
      chk({tag, ".timed_out"}, timed_out, 1);
    end
  endtask

  task automatic run_shot(input string tag, input int d, input int h);
    measure = 1'b1; tick(); measure = 1'b0;
    chk({tag, ".trig_on"}, trig, 1);
    chk({tag, ".busy_on"}, busy, 1);
    finish_shot(tag, d, h);
  endtask

  // Called on the ready cycle: ready must drop next cycle, busy after holdoff.
  task automatic idle_check(input string tag);
    int lat;
    lat = 0;
    do begin
      tick(); lat++;
      if (lat == 1) chk({tag, ".ready_1cyc"}, ready, 0);
    end while (busy && lat < HOLD + 20);
    chk({tag, ".busy_low_lat_ok"}, (lat >= HOLD - 1 && lat <= HOLD + 2), 1);
  endtask

  initial begin
    int rc, rr, n, d, h;
    rst = 1'b1; measure = 1'b0; echo = 1'b0;
    tick(3);
    chk("rst.trig", trig, 0);
    chk("rst.busy", busy, 0);
    chk("rst.ready", ready, 0);
    chk("rst.distance", distance, 0);
    chk("rst.timed_out", timed_out, 0);
    rst = 1'b0;
    tick(4);
    chk("idle.no_trig", trig_rises, 0);

    run_shot("d237", 20, 237);
    idle_check("d237");
    tick(10);
    chk("d237.single_trig", trig_rises, 1);

    run_shot("sat", 0, 3000);
    idle_check("sat");
    run_shot("d95", 7, 95);
    idle_check("d95");

    run_shot("noecho", 0, 0);
    idle_check("noecho");
    echo = 1'b1; tick(5);
    run_shot("echohigh", 0, 0);
    idle_check("echohigh");
    echo = 1'b0; tick(5);

    // Request during holdoff is remembered and fires once holdoff ends.
    run_shot("pend_a", 12, 64);
    tick(10);
    measure = 1'b1; tick(); measure = 1'b0;
    n = 0;
    while (!trig && n < HOLD + 20) begin tick(); n++; end
    chk("pend.trig_lat_ok", (11 + n >= HOLD && 11 + n <= HOLD + 3), 1);
    chk("pend.busy", busy, 1);
    finish_shot("pend_b", 3, 128);
    idle_check("pend_b");

    // Requests while the echo is being timed are dropped.
    measure = 1'b1; tick(); measure = 1'b0;
    rr = ready_cnt;
    while (trig) tick();
    tick(5); echo = 1'b1; tick(30);
    measure = 1'b1; tick(); measure = 1'b0; tick(30);
    measure = 1'b1; tick(); measure = 1'b0; tick(40);
    echo = 1'b0;
    wait_ready(20, n, rc[0]);
    chk("ign.distance", distance, exp_dist(102));
    rc = trig_rises;
    idle_check("ign");
    tick(30);
    chk("ign.no_retrig", trig_rises, rc);
    chk("ign.one_result", ready_cnt - rr, 1);

    // Reset while timing the echo discards the measurement.
    measure = 1'b1; tick(); measure = 1'b0;
    while (trig) tick();
    tick(3); echo = 1'b1; tick(40);
    rr = ready_cnt;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst.trig", trig, 0);
    chk("midrst.busy", busy, 0);
    chk("midrst.distance", distance, 0);
    chk("midrst.ready", ready, 0);
    echo = 1'b0; tick(20);
    chk("midrst.no_ready", ready_cnt, rr);
    run_shot("after_rst", 10, 50);
    idle_check("after_rst");

    for (int i = 0; i < 8; i++) begin
      tick($urandom_range(0, 20));
      d = $urandom_range(0, 100);
      h = (i % 2 == 0) ? $urandom_range(1, 60) : $urandom_range(1, 3000);
      run_shot($sformatf("rnd%0d", i), d, h);
      idle_check($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
